instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH SHALL default to 4 and set the FIFO entries; it SHALL be a power of two.
REQ-003 Parameter AW SHALL default to 16 and set the address width.
REQ-004 Parameter IW SHALL default to 32 and set the instruction width.
REQ-005 Port clk SHALL be an input, 1 bit: the clock.
REQ-006 Port reset SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-007 Port pc_in SHALL be an input, AW bits: fetch address from the PC unit.
REQ-008 Port pc_valid SHALL be an input, 1 bit: pc_in is valid.
REQ-009 Port pc_ready SHALL be an output, 1 bit: the buffer accepts pc_in this cycle.
REQ-010 Port flush SHALL be an input, 1 bit: taken branch; discard all fetched and in-flight words.
REQ-011 Port mem_req SHALL be an output, 1 bit: instruction memory read strobe.
REQ-012 Port mem_addr SHALL be an output, AW bits: instruction memory address.
REQ-013 Port mem_rdata SHALL be an input, IW bits: memory data, valid one cycle after mem_req.
REQ-014 Port instr_out SHALL be an output, IW bits: instruction to decode.
REQ-015 Port instr_pc SHALL be an output, AW bits: address of instr_out.
REQ-016 Port instr_valid SHALL be an output, 1 bit: instr_out is valid.
REQ-017 Port dec_ready SHALL be an input, 1 bit: decode consumes instr_out this cycle.
REQ-018 Port fifo_count SHALL be an output, clog2(DEPTH)+1 bits: occupied FIFO entries.

Function
REQ-019 An address SHALL be accepted in any cycle with pc_valid=1 and pc_ready=1.
REQ-020 mem_req SHALL equal pc_valid AND pc_ready, and mem_addr SHALL equal pc_in (combinational).
REQ-021 An inflight flag and register SHALL capture the accepted address at the clock edge.
REQ-022 In the next cycle, the returning mem_rdata and its address SHALL be written to the FIFO at wr_ptr.
REQ-023 pc_ready SHALL be 1 only when the state is RUN, flush=0, and fifo_count + inflight < DEPTH; a same-cycle pop SHALL not be credited.
REQ-024 instr_valid SHALL be 1 when fifo_count > 0; instr_out and instr_pc SHALL come from the entry at rd_ptr.
REQ-025 A pop SHALL occur on instr_valid AND dec_ready; rd_ptr SHALL advance by 1, wrapping modulo DEPTH.
REQ-026 wr_ptr SHALL advance by 1 per write, wrapping modulo DEPTH.
REQ-027 When a push and a pop occur in the same cycle, fifo_count SHALL be unchanged.
REQ-028 Without bypass, latency from acceptance in cycle N to instr_valid SHALL be cycle N+2.
REQ-029 The FSM SHALL have two states, RUN and FLUSH.
REQ-030 In RUN, flush=1 SHALL clear both pointers, fifo_count and inflight, and the next state SHALL be FLUSH.
REQ-031 In FLUSH, pc_ready=0, instr_valid=0, and any memory return SHALL be dropped; the next state SHALL be RUN unconditionally.
REQ-032 flush SHALL have priority over push, pop and acceptance in the same cycle; a return arriving with flush SHALL be dropped.
REQ-033 instr_out and instr_pc SHALL drive 0 when instr_valid=0.

Reset
REQ-034 Asserting reset SHALL immediately force: state RUN, both pointers 0, inflight 0, fifo_count 0, instr_valid 0, instr_out 0, instr_pc 0, mem_req 0, pc_ready 0.
REQ-035 Reset mid-operation SHALL discard all FIFO contents and in-flight words.
REQ-036 pc_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-037 When the macro IFB_BYPASS_EN is defined, a return arriving with fifo_count=0, no flush and dec_ready=1 SHALL be presented directly on instr_out, instr_pc and instr_valid in the same cycle (latency N+1) and SHALL not be written to the FIFO.
REQ-038 When IFB_BYPASS_EN is defined and dec_ready=0, the return SHALL be written to the FIFO normally.
REQ-039 When IFB_BYPASS_EN is undefined, every return SHALL pass through the FIFO (latency N+2), and there SHALL be no combinational path from mem_rdata to the outputs.

Verification
REQ-040 Basic fetch: pc_in=0x0010 accepted at cycle 1, mem_rdata=0xE0811002 at cycle 2, dec_ready=1 -> at cycle 3 instr_valid=1, instr_out=0xE0811002, instr_pc=0x0010 (cycle 2 with IFB_BYPASS_EN).
REQ-041 Full: dec_ready=0, pc_valid=1 on addresses 0x0000 to 0x0005 -> exactly 4 accepted, pc_ready=0 afterwards, fifo_count=4; draining yields 0x0000 to 0x0003 in order.
REQ-042 Wrap-around: 10 back-to-back fetches with dec_ready=1 -> pointers wrap, outputs arrive in order, and fifo_count never exceeds 4.
REQ-043 Flush: fifo_count=3 with one word in flight, flush=1 -> next cycle fifo_count=0, instr_valid=0, pc_ready=0; the in-flight word never appears; pc_ready=1 the cycle after.
REQ-044 Simultaneous push and pop at fifo_count=2 -> fifo_count stays 2.
REQ-045 Reset asserted asynchronously between clock edges with fifo_count=2 -> instr_valid=0 and fifo_count=0 before the next edge.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - instruction fetch buffer: one-deep memory pipeline into a DEPTH-entry FIFO
// Optional same-cycle bypass of an empty FIFO is enabled by defining IFB_BYPASS_EN.
module instr_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            pc_in,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic [IW-1:0]            mem_rdata,
  output logic [IW-1:0]            instr_out,
  output logic [AW-1:0]            instr_pc,
  output logic                     instr_valid,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [AW-1:0]   inflight_pc;
  logic [IW-1:0]   data_q [DEPTH];
  logic [AW-1:0]   pc_q   [DEPTH];

  logic            fifo_valid;
  logic            bypass;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;

  // The in-flight word already owns a slot, so it counts against capacity.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign pc_ready   = !reset && (state == RUN) && !flush && (occupancy < (CW+1)'(DEPTH));
  assign mem_req    = pc_valid && pc_ready;
  assign mem_addr   = pc_in;
  assign fifo_count = count;
  assign fifo_valid = (state == RUN) && (count != '0);

`ifdef IFB_BYPASS_EN
  assign bypass      = (state == RUN) && inflight && !flush && (count == '0) && dec_ready;
  assign instr_valid = fifo_valid || bypass;
  assign instr_out   = bypass ? mem_rdata   : (fifo_valid ? data_q[rd_ptr] : '0);
  assign instr_pc    = bypass ? inflight_pc : (fifo_valid ? pc_q[rd_ptr]   : '0);
`else
  assign bypass      = 1'b0;
  assign instr_valid = fifo_valid;
  assign instr_out   = fifo_valid ? data_q[rd_ptr] : '0;
  assign instr_pc    = fifo_valid ? pc_q[rd_ptr]   : '0;
`endif

  assign push = (state == RUN) && inflight && !flush && !bypass;
  assign pop  = fifo_valid && dec_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            state    <= FLUSH;
          end else begin
            inflight <= mem_req;
            if (mem_req) inflight_pc <= pc_in;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
              2'b10:   count <= count + CW'(1);
              2'b01:   count <= count - CW'(1);
              default: count <= count;
            endcase
          end
        end
        default: begin
          inflight <= 1'b0;
          state    <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - self-checking bench for instr_fetch_buffer against a queue reference model
module tb_instr_fetch_buffer;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic [2:0]  fifo_count;

  instr_fetch_buffer #(.DEPTH(4), .AW(16), .IW(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .dec_ready(dec_ready), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] d;
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  ent_t        q[$];
  logic        m_infl = 1'b0;
  logic [15:0] m_infl_pc = '0;
  logic        m_fl = 1'b0;
  logic        last_ready, last_req, last_valid;
  logic [31:0] last_out;
  logic [15:0] last_pc;
  logic [2:0]  last_count;
  int          acc;
  logic [15:0] addr;

  function automatic logic [31:0] rdata_of(input logic [15:0] a);
    if (a == 16'h0010) return 32'hE0811002;
    return {a ^ 16'hBEEF, a + 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model at the rising edge.
  task automatic cyc(input logic pv, input logic [15:0] pa, input logic fl, input logic dr);
    logic        e_ready;
    logic        e_valid;
    logic        byp;
    logic [31:0] e_out;
    logic [15:0] e_pc;
    ent_t        e;
    pc_valid  = pv;
    pc_in     = pa;
    flush     = fl;
    dec_ready = dr;
    mem_rdata = m_infl ? rdata_of(m_infl_pc) : $urandom();
    #1;
    e_ready = !m_fl && !fl && ((q.size() + int'(m_infl)) < 4);
    byp = 1'b0;
`ifdef IFB_BYPASS_EN
    byp = !m_fl && !fl && m_infl && (q.size() == 0) && dr;
`endif
    e_valid = (!m_fl && q.size() > 0) || byp;
    e_out = '0;
    e_pc  = '0;
    if (byp) begin
      e_out = rdata_of(m_infl_pc);
      e_pc  = m_infl_pc;
    end else if (e_valid) begin
      e_out = q[0].d;
      e_pc  = q[0].pc;
    end
    check("pc_ready", 32'(pc_ready), 32'(e_ready));
    check("mem_req", 32'(mem_req), 32'(pv && e_ready));
    if (pv && e_ready) check("mem_addr", 32'(mem_addr), 32'(pa));
    check("instr_valid", 32'(instr_valid), 32'(e_valid));
    check("instr_out", instr_out, e_out);
    check("instr_pc", 32'(instr_pc), 32'(e_pc));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    last_ready = pc_ready;
    last_req   = mem_req;
    last_valid = instr_valid;
    last_out   = instr_out;
    last_pc    = instr_pc;
    last_count = fifo_count;
    @(posedge clk);
    if (m_fl) begin
      m_fl = 1'b0;
    end else if (fl) begin
      q.delete();
      m_infl = 1'b0;
      m_fl   = 1'b1;
    end else begin
      if (e_valid && dr && !byp) void'(q.pop_front());
      if (m_infl && !byp) begin
        e.pc = m_infl_pc;
        e.d  = rdata_of(m_infl_pc);
        q.push_back(e);
      end
      m_infl    = pv && e_ready;
      m_infl_pc = pa;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pc_valid = 1'b1; pc_in = 16'h0042; flush = 1'b0; dec_ready = 1'b1; mem_rdata = '0;
    #2;
    check("rst_pc_ready", 32'(pc_ready), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic fetch of 0x0010
    cyc(1, 16'h0010, 0, 1);
    check("first_ready", 32'(last_ready), 1);
    cyc(0, 16'h0000, 0, 1);
`ifndef IFB_BYPASS_EN
    cyc(0, 16'h0000, 0, 1);
`endif
    check("basic_valid", 32'(last_valid), 1);
    check("basic_out", last_out, 32'hE0811002);
    check("basic_pc", 32'(last_pc), 32'h0010);
    repeat (2) cyc(0, 16'h0000, 0, 1);

    // Fill with decode stalled
    addr = 16'h0000; acc = 0;
    repeat (8) begin
      cyc(addr <= 16'h0005, addr, 0, 0);
      if (last_req) begin acc++; addr++; end
    end
    check("full_accepts", 32'(acc), 4);
    check("full_count", 32'(last_count), 4);
    check("full_ready", 32'(last_ready), 0);
    repeat (6) cyc(0, 16'h0000, 0, 1);

    // Back-to-back fetches wrapping the pointers
    addr = 16'h0100; acc = 0;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      cyc(1, addr, 0, 1);
      if (last_req) begin acc++; addr++; end
    end
    check("wrap_accepts", 32'(acc), 10);
    repeat (3) cyc(0, 16'h0000, 0, 1);

    // Flush with three buffered and one in flight
    for (int k = 0; k < 4; k++) cyc(1, 16'h0200 + 16'(k), 0, 0);
    cyc(1, 16'h0300, 1, 0);
    check("flush_pre_count", 32'(last_count), 3);
    cyc(1, 16'h0300, 0, 1);
    check("flush_count", 32'(last_count), 0);
    check("flush_valid", 32'(last_valid), 0);
    check("flush_ready", 32'(last_ready), 0);
    cyc(1, 16'h0300, 0, 1);
    check("flush_ready_after", 32'(last_ready), 1);
    repeat (4) cyc(0, 16'h0000, 0, 1);

    // Simultaneous push and pop at count 2
    cyc(1, 16'h0400, 0, 0);
    cyc(1, 16'h0401, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    cyc(1, 16'h0402, 0, 0);
    cyc(1, 16'h0403, 0, 1);
    check("pushpop_pre", 32'(last_count), 2);
    cyc(0, 16'h0000, 0, 0);
    check("pushpop_count", 32'(last_count), 2);
    repeat (6) cyc(0, 16'h0000, 0, 1);

    // Randomized traffic
    repeat (400) cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 16) == 0, ($urandom % 3) != 0);
    repeat (8) cyc(0, 16'h0000, 0, 1);

    // Asynchronous reset between edges with two entries buffered
    cyc(1, 16'h0500, 0, 0);
    cyc(1, 16'h0501, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    pc_valid = 1'b1; pc_in = 16'h0600; dec_ready = 1'b0; flush = 1'b0;
    #1;
    check("arst_pre_count", 32'(fifo_count), 2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_ready", 32'(pc_ready), 0);
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_out", instr_out, 0);
    check("arst_pc", 32'(instr_pc), 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); m_infl = 1'b0; m_fl = 1'b0;
    cyc(1, 16'h0700, 0, 1);
    check("arst_ready_after", 32'(last_ready), 1);
    repeat (4) cyc(0, 16'h0000, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
